// File: rtl/mitchell_dot_acc.sv
// mitchell_dot_acc: streaming dot-product accumulator for the Mitchell log
// multiplier. It sums VEC_LEN signed 17-bit products into one ACC_W-bit result
// and holds that result in a one-entry valid/ready output slot. The next
// vector accumulates while the previous result waits in the slot.
module mitchell_dot_acc #(
  parameter int VEC_LEN = 8,
  parameter int ACC_W   = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [16:0]      in_p,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             busy
);

  // A one-product vector still needs a 1-bit counter so the types stay legal.
  localparam int CNT_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(VEC_LEN - 1);

  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] p_ext;
  logic [ACC_W-1:0] sum;
  logic             is_last;
  logic             accept;
  logic             xfer;

  // Sign-extend the product, then form the running sum. The sum wraps
  // modulo 2^ACC_W, with no saturation.
  always_comb begin
    p_ext   = ACC_W'($signed(in_p));
    sum     = acc + p_ext;
    is_last = (cnt == LAST);
    // Only a last product can stall, and only while the slot is full and not
    // draining. This is the block's sole combinational path (out_ready -> in_ready).
    in_ready = !(is_last && out_valid && !out_ready);
    // clr drops the product offered in the same cycle.
    accept   = in_valid && in_ready && !clr;
    xfer     = out_valid && out_ready;
    busy     = (cnt != '0);
  end

  // Partial accumulation: clr aborts it, and a last product restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
    end else if (clr) begin
      acc <= '0;
      cnt <= '0;
    end else if (accept) begin
      if (is_last) begin
        acc <= '0;
        cnt <= '0;
      end else begin
        acc <= sum;
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Result slot. A new result may overwrite the slot in the same cycle that
  // the old one drains. clr leaves the slot unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_sum   <= '0;
      out_valid <= 1'b0;
    end else if (accept && is_last) begin
      out_sum   <= sum;
      out_valid <= 1'b1;
    end else if (xfer) begin
      out_valid <= 1'b0;
    end
  end

endmodule
